// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: machine word, fetch FSM encoding and
// the instruction queue entry.
package fetch_unit_pkg;

    typedef logic [15:0] lc3b_word;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t FETCH_IDLE    = 2'd0;
    localparam fetch_state_t FETCH_REQ     = 2'd1;
    localparam fetch_state_t FETCH_DISCARD = 2'd2;

    typedef struct packed {
        lc3b_word instr;
        lc3b_word pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// Circular instruction queue between I-cache returns and issue.
// Flush empties it in one cycle; pointers wrap modulo DEPTH.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enq,
    input  fetch_entry_t             i_enq_data,
    input  logic                     i_deq,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_do_enq;
    logic          w_do_deq;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_head];
    assign w_do_enq = i_enq & ~o_full & ~i_flush;
    assign w_do_deq = i_deq & ~o_empty & ~i_flush;

    // Entry storage; contents are don't-care while not counted.
    always_ff @(posedge clk) begin
        if (w_do_enq) begin
            r_mem[r_tail] <= i_enq_data;
        end
    end

    // Pointer and occupancy tracking; flush and reset both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_enq) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_do_deq) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, I-cache request FSM and
// redirect handling, feeding a small queue read by issue.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int       QDEPTH   = 4,
    parameter lc3b_word RESET_PC = 16'h0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pcmux_sel,
    input  logic [15:0] br_pc,
    input  logic        rob_flush,
    input  logic [15:0] rob_flush_pc,
    output logic        icache_read,
    output logic [15:0] icache_address,
    input  logic        icache_resp,
    input  logic [15:0] icache_rdata,
    output logic [15:0] instr,
    output logic        instr_is_new,
    output logic [15:0] curr_pc
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t  r_state;
    fetch_state_t  w_state_nx;
    lc3b_word      r_fetch_pc;
    lc3b_word      w_fetch_pc_nx;
    lc3b_word      r_stale_addr;
    lc3b_word      w_pc_inc;
    lc3b_word      w_target;
    logic          w_redirect;
    logic          w_enq;
    logic          w_deq;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_after;
    fetch_entry_t  w_head;
    fetch_entry_t  w_enq_data;

    assign w_redirect    = rob_flush | pcmux_sel;
    assign w_target      = rob_flush ? rob_flush_pc : br_pc;
    assign w_pc_inc      = r_fetch_pc + 16'd2;
    assign w_deq         = ~w_empty & ~stall & ~w_redirect;
    assign w_count_after = w_count + CW'(1) - CW'(w_deq);
    assign w_enq_data    = '{instr: icache_rdata, pc: w_pc_inc};

    fetch_queue #(
        .DEPTH      (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_enq      (w_enq & ~w_full),
        .i_enq_data (w_enq_data),
        .i_deq      (w_deq),
        .i_flush    (w_redirect),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

    // Next fetch state and PC; a redirect overrides any normal progress.
    always_comb begin
        w_state_nx    = r_state;
        w_fetch_pc_nx = r_fetch_pc;
        w_enq         = 1'b0;
        if (w_redirect) begin
            w_fetch_pc_nx = w_target;
            case (r_state)
                FETCH_REQ:     w_state_nx = icache_resp ? FETCH_REQ
                                                        : FETCH_DISCARD;
                FETCH_DISCARD: w_state_nx = icache_resp ? FETCH_REQ
                                                        : FETCH_DISCARD;
                default:       w_state_nx = FETCH_REQ;
            endcase
        end else begin
            case (r_state)
                FETCH_IDLE: begin
                    if (w_count < CW'(QDEPTH)) begin
                        w_state_nx = FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (icache_resp) begin
                        w_enq         = 1'b1;
                        w_fetch_pc_nx = w_pc_inc;
                        w_state_nx    = (w_count_after < CW'(QDEPTH))
                                        ? FETCH_REQ : FETCH_IDLE;
                    end
                end
                FETCH_DISCARD: begin
                    if (icache_resp) begin
                        w_state_nx = FETCH_REQ;
                    end
                end
                default: w_state_nx = FETCH_IDLE;
            endcase
        end
    end

    // State, PC and the address of a request whose data will be dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_stale_addr <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_fetch_pc <= w_fetch_pc_nx;
            if (r_state == FETCH_REQ && w_state_nx == FETCH_DISCARD) begin
                r_stale_addr <= r_fetch_pc;
            end
        end
    end

    assign icache_read    = (r_state == FETCH_REQ) |
                            (r_state == FETCH_DISCARD);
    assign icache_address = (r_state == FETCH_DISCARD) ? r_stale_addr
                                                       : r_fetch_pc;
    assign instr_is_new   = ~w_empty;
    assign instr          = w_empty ? 16'h0 : w_head.instr;
    assign curr_pc        = w_empty ? 16'h0 : w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: random cache latency, stalls,
// redirects and resets against an instruction-stream model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        pcmux_sel = 1'b0;
    logic [15:0] br_pc = 16'h0;
    logic        rob_flush = 1'b0;
    logic [15:0] rob_flush_pc = 16'h0;
    logic        icache_read;
    logic [15:0] icache_address;
    logic        icache_resp = 1'b0;
    logic [15:0] icache_rdata = 16'h0;
    logic [15:0] instr;
    logic        instr_is_new;
    logic [15:0] curr_pc;

    logic        read2;
    logic [15:0] addr2;
    logic        resp2;
    logic [15:0] rdata2;
    logic [15:0] instr2;
    logic        new2;
    logic [15:0] curr2;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    fetch_unit #(.QDEPTH(4), .RESET_PC(16'h0)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .pcmux_sel      (pcmux_sel),
        .br_pc          (br_pc),
        .rob_flush      (rob_flush),
        .rob_flush_pc   (rob_flush_pc),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_resp    (icache_resp),
        .icache_rdata   (icache_rdata),
        .instr          (instr),
        .instr_is_new   (instr_is_new),
        .curr_pc        (curr_pc)
    );

    assign resp2  = read2;
    assign rdata2 = memf(addr2);

    fetch_unit #(.QDEPTH(4), .RESET_PC(16'hFFFC)) u_dut2 (
        .clk            (clk),
        .rst            (rst),
        .stall          (1'b0),
        .pcmux_sel      (1'b0),
        .br_pc          (16'h0),
        .rob_flush      (1'b0),
        .rob_flush_pc   (16'h0),
        .icache_read    (read2),
        .icache_address (addr2),
        .icache_resp    (resp2),
        .icache_rdata   (rdata2),
        .instr          (instr2),
        .instr_is_new   (new2),
        .curr_pc        (curr2)
    );

    // I-cache model with configurable response latency
    int          lat_min = 0;
    int          lat_max = 0;
    bit          busy = 0;
    int          cnt = 0;
    logic [15:0] busy_addr = 16'h0;
    logic [15:0] req_q[$];

    always @(posedge clk) begin
        #1;
        icache_resp  = 1'b0;
        icache_rdata = 16'($urandom);
        if (!icache_read) begin
            busy = 0;
        end else begin
            if (!busy) begin
                busy      = 1;
                busy_addr = icache_address;
                cnt       = $urandom_range(lat_max, lat_min);
                req_q.push_back(icache_address);
            end else begin
                chk("addr_hold", icache_address, busy_addr);
                cnt--;
            end
            if (cnt <= 0) begin
                icache_resp  = 1'b1;
                icache_rdata = memf(busy_addr);
                busy         = 0;
            end
        end
    end

    // Expected instruction stream: sequential words from the last target
    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_next = 16'h0;
    logic        rst_q = 1'b0;
    logic        redir_q = 1'b0;

    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{instr: memf(exp_next), pc: exp_next + 16'd2});
            exp_next = exp_next + 16'd2;
        end
    endtask

    task automatic restart(input logic [15:0] t);
        exp_q.delete();
        exp_next = t;
        topup();
    endtask

    always @(posedge clk) begin
        rst_q   <= rst;
        redir_q <= (rob_flush | pcmux_sel) & ~rst;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_q) begin
            chk("rst_read", 16'(icache_read), 16'h0);
            chk("rst_valid", 16'(instr_is_new), 16'h0);
            chk("rst_instr", instr, 16'h0);
            chk("rst_curr_pc", curr_pc, 16'h0);
        end
        if (redir_q) begin
            chk("valid_after_redirect", 16'(instr_is_new), 16'h0);
        end
        if (!instr_is_new && !rst_q) begin
            chk("empty_nop", instr | curr_pc, 16'h0);
        end
        if (rst) begin
            restart(16'h0);
        end else if (rob_flush) begin
            restart(rob_flush_pc);
        end else if (pcmux_sel) begin
            restart(br_pc);
        end else if (instr_is_new && !stall) begin
            e = exp_q.pop_front();
            chk("issue_instr", instr, e.instr);
            chk("issue_curr_pc", curr_pc, e.pc);
            topup();
        end
    end

    // Wrap-around stream of the second instance after each reset
    int n2 = 0;

    always @(negedge clk) begin
        logic [15:0] a;
        if (rst) begin
            n2 = 0;
        end else if (new2 && n2 < 3) begin
            a = 16'hFFFC + 16'(2 * n2);
            chk("wrap_instr", instr2, memf(a));
            chk("wrap_curr_pc", curr2, a + 16'd2);
            n2++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        req_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_read(input string name);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (icache_read) begin
                seen = 1;
                break;
            end
            cyc();
        end
        chk(name, 16'(seen), 16'h1);
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 30 && req_q.size() == 0; i++) begin
            cyc();
        end
        chk(name, 16'(req_q.size() > 0), 16'h1);
    endtask

    initial begin
        // Basic stream with a single-cycle cache
        lat_min = 0;
        lat_max = 0;
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t1_valid_c0", 16'(instr_is_new), 16'h0);
        @(negedge clk);
        chk("t1_read_c1", 16'(icache_read), 16'h1);
        chk("t1_addr_c1", icache_address, 16'h0);
        chk("t1_valid_c1", 16'(instr_is_new), 16'h0);
        @(negedge clk);
        chk("t1_valid_c2", 16'(instr_is_new), 16'h1);
        chk("t1_curr_pc", curr_pc, 16'h0002);
        repeat (10) cyc();

        // Held stall fills the queue and stops requests
        stall = 1'b1;
        repeat (12) cyc();
        @(negedge clk);
        chk("t2_read_full", 16'(icache_read), 16'h0);
        chk("t2_valid_full", 16'(instr_is_new), 16'h1);
        chk("t2_head_pc", curr_pc, exp_q[0].pc);
        cyc();
        stall = 1'b0;
        repeat (10) cyc();

        // Redirect while a slow response is outstanding
        lat_min = 3;
        lat_max = 3;
        do_reset();
        cyc();
        wait_read("t3_first_req");
        cyc();
        pcmux_sel = 1'b1;
        br_pc     = 16'h0040;
        cyc();
        pcmux_sel = 1'b0;
        repeat (14) cyc();
        chk("t3_req_count", 16'(req_q.size() >= 2), 16'h1);
        if (req_q.size() >= 2) begin
            chk("t3_stale_addr", req_q[0], 16'h0000);
            chk("t3_new_addr", req_q[1], 16'h0040);
        end

        // Simultaneous flush and branch redirect
        lat_min = 0;
        lat_max = 2;
        repeat (5) cyc();
        rob_flush    = 1'b1;
        rob_flush_pc = 16'h0100;
        pcmux_sel    = 1'b1;
        br_pc        = 16'h0040;
        @(negedge clk);
        req_q.delete();
        cyc();
        rob_flush = 1'b0;
        pcmux_sel = 1'b0;
        wait_req("t4_req_seen");
        if (req_q.size() > 0) begin
            chk("t4_flush_wins", req_q[0], 16'h0100);
        end
        repeat (10) cyc();

        // Reset while a stale response is being discarded
        lat_min = 6;
        lat_max = 6;
        stall   = 1'b1;
        do_reset();
        cyc();
        wait_read("t6_first_req");
        cyc();
        pcmux_sel = 1'b1;
        br_pc     = 16'h0200;
        cyc();
        pcmux_sel = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("t6_discard_read", 16'(icache_read), 16'h1);
        cyc();
        @(negedge clk);
        chk("t6_rst_read", 16'(icache_read), 16'h0);
        chk("t6_rst_valid", 16'(instr_is_new), 16'h0);
        req_q.delete();
        cyc();
        rst   = 1'b0;
        stall = 1'b0;
        lat_min = 0;
        lat_max = 1;
        wait_req("t6_req_seen");
        if (req_q.size() > 0) begin
            chk("t6_restart_pc", req_q[0], 16'h0000);
        end
        repeat (10) cyc();

        // Randomised traffic
        lat_min = 0;
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst          = ($urandom_range(0, 199) == 0);
            stall        = ($urandom_range(0, 99) < 30);
            rob_flush    = ($urandom_range(0, 99) < 3);
            pcmux_sel    = ($urandom_range(0, 99) < 6);
            br_pc        = 16'($urandom) & 16'hFFFE;
            rob_flush_pc = 16'($urandom) & 16'hFFFE;
        end
        cyc();
        rst       = 1'b0;
        stall     = 1'b0;
        rob_flush = 1'b0;
        pcmux_sel = 1'b0;
        repeat (10) cyc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
